// File: rtl/core_pkg.sv
// Shared types for the 2-wide MIPS core pipeline.
// Holds the ID/EX slot bundle and its bubble constant.
package core_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [3:0] {
        ALU_NOP    = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_XOR    = 4'd5,
        ALU_NOR    = 4'd6,
        ALU_SLT    = 4'd7,
        ALU_SLTU   = 4'd8,
        ALU_SLL    = 4'd9,
        ALU_SRL    = 4'd10,
        ALU_SRA    = 4'd11,
        ALU_LUI    = 4'd12,
        ALU_MUL    = 4'd13,
        ALU_PASS_A = 4'd14,
        ALU_PASS_B = 4'd15
    } alu_op_t;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs_data;
        logic [DATA_W-1:0] rt_data;
        logic [DATA_W-1:0] imm;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic [REG_W-1:0]  rd;
        alu_op_t           alu_op;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              jal;
    } id_ex_slot_t;

    localparam id_ex_slot_t BUBBLE_SLOT = id_ex_slot_t'('0);

endpackage

// File: rtl/id_ex_slot.sv
// One way of the ID/EX register: load, bubble or hold.
// Invalid inputs are loaded as bubbles so reg_write implies valid.
module id_ex_slot
    import core_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_kill,
    input  logic        i_hold,
    input  id_ex_slot_t i_d,
    output id_ex_slot_t o_q
);

    id_ex_slot_t r_q;
    logic        w_bubble;

    assign w_bubble = i_kill | ~i_d.valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= BUBBLE_SLOT;
        end else if (!i_hold) begin
            r_q <= w_bubble ? BUBBLE_SLOT : i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/id_ex_dual_reg.sv
// Dual-way ID/EX pipeline register with age bit, flush/stall/squash
// control and saturating issue-width counters.
module id_ex_dual_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              hold_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              squash_young_i,
    input  logic              way0_oldest_D,
    input  logic              way0_valid_D,
    input  logic [DATA_W-1:0] way0_pc_D,
    input  logic [DATA_W-1:0] way0_rs_data_D,
    input  logic [DATA_W-1:0] way0_rt_data_D,
    input  logic [DATA_W-1:0] way0_imm_D,
    input  logic [REG_W-1:0]  way0_rs_D,
    input  logic [REG_W-1:0]  way0_rt_D,
    input  logic [REG_W-1:0]  way0_rd_D,
    input  logic [3:0]        way0_alu_op_D,
    input  logic              way0_reg_write_D,
    input  logic              way0_mem_read_D,
    input  logic              way0_mem_write_D,
    input  logic              way0_jal_D,
    input  logic              way1_valid_D,
    input  logic [DATA_W-1:0] way1_pc_D,
    input  logic [DATA_W-1:0] way1_rs_data_D,
    input  logic [DATA_W-1:0] way1_rt_data_D,
    input  logic [DATA_W-1:0] way1_imm_D,
    input  logic [REG_W-1:0]  way1_rs_D,
    input  logic [REG_W-1:0]  way1_rt_D,
    input  logic [REG_W-1:0]  way1_rd_D,
    input  logic [3:0]        way1_alu_op_D,
    input  logic              way1_reg_write_D,
    input  logic              way1_mem_read_D,
    input  logic              way1_mem_write_D,
    input  logic              way1_jal_D,
    output logic              way0_valid_E,
    output logic [DATA_W-1:0] way0_pc_E,
    output logic [DATA_W-1:0] way0_rs_data_E,
    output logic [DATA_W-1:0] way0_rt_data_E,
    output logic [DATA_W-1:0] way0_imm_E,
    output logic [REG_W-1:0]  way0_rs_E,
    output logic [REG_W-1:0]  way0_rt_E,
    output logic [REG_W-1:0]  way0_rd_E,
    output logic [3:0]        way0_alu_op_E,
    output logic              way0_reg_write_E,
    output logic              way0_mem_read_E,
    output logic              way0_mem_write_E,
    output logic              way0_jal_E,
    output logic              way1_valid_E,
    output logic [DATA_W-1:0] way1_pc_E,
    output logic [DATA_W-1:0] way1_rs_data_E,
    output logic [DATA_W-1:0] way1_rt_data_E,
    output logic [DATA_W-1:0] way1_imm_E,
    output logic [REG_W-1:0]  way1_rs_E,
    output logic [REG_W-1:0]  way1_rt_E,
    output logic [REG_W-1:0]  way1_rd_E,
    output logic [3:0]        way1_alu_op_E,
    output logic              way1_reg_write_E,
    output logic              way1_mem_read_E,
    output logic              way1_mem_write_E,
    output logic              way1_jal_E,
    output logic              way0_oldest_E,
    output logic [CNT_W-1:0]  cnt_dual_o,
    output logic [CNT_W-1:0]  cnt_single_o,
    output logic [CNT_W-1:0]  cnt_empty_o
);

    import core_pkg::*;

    id_ex_slot_t      w_d0, w_d1, w_q0, w_q1;
    logic             w_hold, w_kill_all, w_kill0, w_kill1;
    logic             w_nv0, w_nv1;
    logic             r_age;
    logic [CNT_W-1:0] r_cnt_dual, r_cnt_single, r_cnt_empty;

    // Flush overrides hold so a redirect lands even during a memory stall.
    assign w_hold     = hold_i & ~flush_i;
    assign w_kill_all = flush_i | stall_i;
    assign w_kill0    = w_kill_all | (squash_young_i & ~way0_oldest_D);
    assign w_kill1    = w_kill_all | (squash_young_i &  way0_oldest_D);

    assign w_nv0 = way0_valid_D & ~w_kill0;
    assign w_nv1 = way1_valid_D & ~w_kill1;

    always_comb begin
        w_d0           = BUBBLE_SLOT;
        w_d0.valid     = way0_valid_D;
        w_d0.pc        = way0_pc_D;
        w_d0.rs_data   = way0_rs_data_D;
        w_d0.rt_data   = way0_rt_data_D;
        w_d0.imm       = way0_imm_D;
        w_d0.rs        = way0_rs_D;
        w_d0.rt        = way0_rt_D;
        w_d0.rd        = way0_rd_D;
        w_d0.alu_op    = alu_op_t'(way0_alu_op_D);
        w_d0.reg_write = way0_reg_write_D;
        w_d0.mem_read  = way0_mem_read_D;
        w_d0.mem_write = way0_mem_write_D;
        w_d0.jal       = way0_jal_D;
    end

    always_comb begin
        w_d1           = BUBBLE_SLOT;
        w_d1.valid     = way1_valid_D;
        w_d1.pc        = way1_pc_D;
        w_d1.rs_data   = way1_rs_data_D;
        w_d1.rt_data   = way1_rt_data_D;
        w_d1.imm       = way1_imm_D;
        w_d1.rs        = way1_rs_D;
        w_d1.rt        = way1_rt_D;
        w_d1.rd        = way1_rd_D;
        w_d1.alu_op    = alu_op_t'(way1_alu_op_D);
        w_d1.reg_write = way1_reg_write_D;
        w_d1.mem_read  = way1_mem_read_D;
        w_d1.mem_write = way1_mem_write_D;
        w_d1.jal       = way1_jal_D;
    end

    id_ex_slot u_slot0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_kill (w_kill0),
        .i_hold (w_hold),
        .i_d    (w_d0),
        .o_q    (w_q0)
    );

    id_ex_slot u_slot1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_kill (w_kill1),
        .i_hold (w_hold),
        .i_d    (w_d1),
        .o_q    (w_q1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_age <= 1'b1;
        end else if (!w_hold) begin
            r_age <= w_kill_all ? 1'b1 : way0_oldest_D;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_dual   <= '0;
            r_cnt_single <= '0;
            r_cnt_empty  <= '0;
        end else if (!w_hold) begin
            unique case ({w_nv1, w_nv0})
                2'b11: if (r_cnt_dual != '1)
                    r_cnt_dual <= r_cnt_dual + 1'b1;
                2'b00: if (r_cnt_empty != '1)
                    r_cnt_empty <= r_cnt_empty + 1'b1;
                default: if (r_cnt_single != '1)
                    r_cnt_single <= r_cnt_single + 1'b1;
            endcase
        end
    end

    assign way0_valid_E     = w_q0.valid;
    assign way0_pc_E        = w_q0.pc;
    assign way0_rs_data_E   = w_q0.rs_data;
    assign way0_rt_data_E   = w_q0.rt_data;
    assign way0_imm_E       = w_q0.imm;
    assign way0_rs_E        = w_q0.rs;
    assign way0_rt_E        = w_q0.rt;
    assign way0_rd_E        = w_q0.rd;
    assign way0_alu_op_E    = w_q0.alu_op;
    assign way0_reg_write_E = w_q0.reg_write;
    assign way0_mem_read_E  = w_q0.mem_read;
    assign way0_mem_write_E = w_q0.mem_write;
    assign way0_jal_E       = w_q0.jal;

    assign way1_valid_E     = w_q1.valid;
    assign way1_pc_E        = w_q1.pc;
    assign way1_rs_data_E   = w_q1.rs_data;
    assign way1_rt_data_E   = w_q1.rt_data;
    assign way1_imm_E       = w_q1.imm;
    assign way1_rs_E        = w_q1.rs;
    assign way1_rt_E        = w_q1.rt;
    assign way1_rd_E        = w_q1.rd;
    assign way1_alu_op_E    = w_q1.alu_op;
    assign way1_reg_write_E = w_q1.reg_write;
    assign way1_mem_read_E  = w_q1.mem_read;
    assign way1_mem_write_E = w_q1.mem_write;
    assign way1_jal_E       = w_q1.jal;

    assign way0_oldest_E = r_age;
    assign cnt_dual_o    = r_cnt_dual;
    assign cnt_single_o  = r_cnt_single;
    assign cnt_empty_o   = r_cnt_empty;

endmodule
